d_sramlike_bridge: RTL and testbench

D_SRAMLIKE_BRIDGE -- requirements
Module: d_sramlike_bridge

---
 rtl/d_sramlike_bridge.sv | 113 +++++++++++
 tb/tb_d_sramlike_bridge.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/d_sramlike_bridge.sv
// Data-side bridge from the CPU memory stage to an SRAM-like bus (req/addr_ok/data_ok).
// Define DBRIDGE_EXCEPT_GATE_EN to suppress bus requests for accesses flagged with cpu_except.
module d_sramlike_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_except,
  input  logic        cpu_longest_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} stateT;

  stateT       state, nextState;
  logic        go;
  logic        wrQ;
  logic [1:0]  sizeQ;
  logic [31:0] addrQ, wdataQ, holdQ;

`ifdef DBRIDGE_EXCEPT_GATE_EN
  assign go = cpu_en & ~cpu_except;
`else
  assign go = cpu_en;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Request fields are captured on the issue cycle so ADDR can replay them while the CPU side moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrQ    <= 1'b0;
      sizeQ  <= 2'd0;
      addrQ  <= 32'd0;
      wdataQ <= 32'd0;
    end else if (state == IDLE && go) begin
      wrQ    <= |cpu_wen;
      sizeQ  <= cpu_size;
      addrQ  <= cpu_addr;
      wdataQ <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            holdQ <= 32'd0;
    else if (state == DATA && data_ok)  holdQ <= rdata;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (go) nextState = addr_ok ? DATA : ADDR;
      ADDR: if (addr_ok) nextState = DATA;
      DATA: if (data_ok) nextState = cpu_longest_stall ? HOLD : IDLE;
      HOLD: if (!cpu_longest_stall) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Control outputs are gated by rst so they drop immediately, not at the next edge.
  always_comb begin
    req       = 1'b0;
    cpu_stall = 1'b0;
    wr        = wrQ;
    size      = sizeQ;
    addr      = addrQ;
    wdata     = wdataQ;
    cpu_rdata = holdQ;
    unique case (state)
      IDLE: begin
        req       = go;
        cpu_stall = go;
        wr        = |cpu_wen;
        size      = cpu_size;
        addr      = cpu_addr;
        wdata     = cpu_wdata;
      end
      ADDR: begin
        req       = 1'b1;
        cpu_stall = 1'b1;
      end
      DATA: begin
        cpu_stall = ~data_ok;
        if (data_ok) cpu_rdata = rdata;
      end
      HOLD: ;
      default: ;
    endcase
    if (rst) begin
      req       = 1'b0;
      wr        = 1'b0;
      cpu_stall = 1'b0;
    end
  end

endmodule

// File: tb/tb_d_sramlike_bridge.sv
// Directed scoreboard bench for d_sramlike_bridge: stimulus queues expected bus requests and
// load data, a negedge monitor compares them whenever the DUT presents a request or completes a read.
module tb_d_sramlike_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en, cpu_except, cpu_longest_stall;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        wr;
  } reqT;

  reqT         reqQ[$];
  logic [31:0] rdQ[$];
  logic        rdPhase = 1'b0;
  int          checks  = 0;
  int          errors  = 0;

  d_sramlike_bridge dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_except(cpu_except), .cpu_longest_stall(cpu_longest_stall),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares presented requests against the queue head, pops on acceptance.
  always @(negedge clk) begin
    if (!rst) begin
      if (req) begin
        if (reqQ.size() == 0) check("unexpected req", 32'(req), 32'd0);
        else begin
          check("req addr",  addr,          reqQ[0].addr);
          check("req wdata", wdata,         reqQ[0].wdata);
          check("req size",  32'(size),     32'(reqQ[0].size));
          check("req wr",    32'(wr),       32'(reqQ[0].wr));
          if (addr_ok) void'(reqQ.pop_front());
        end
      end
      if (rdPhase) begin
        if (rdQ.size() == 0) check("unexpected read data", 32'd1, 32'd0);
        else check("load data", cpu_rdata, rdQ.pop_front());
      end
    end
  end

  task automatic idleInputs();
    cpu_en = 1'b0; cpu_wen = 4'h0; cpu_except = 1'b0; cpu_longest_stall = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0BAD_0BAD; rdPhase = 1'b0;
  endtask

  // One CPU access with a scripted bus: addr_ok in cycle aDel, data_ok aDel+1+dDel,
  // optional pipeline freeze after completion and optional spurious data_ok before acceptance.
  task automatic access(input string tag, input logic [3:0] wen, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz, input int aDel,
                        input int dDel, input logic [31:0] rd, input int holdCyc,
                        input logic exc, input logic spur);
    int  doneCyc, lastCyc, reqCnt, stallCnt;
    reqT e;
    e.addr = a; e.wdata = wd; e.size = sz; e.wr = |wen;
    reqQ.push_back(e);
    if (wen == 4'h0) rdQ.push_back(rd);
    doneCyc  = aDel + 1 + dDel;
    lastCyc  = doneCyc + ((holdCyc > 0) ? holdCyc + 1 : 0);
    reqCnt   = 0;
    stallCnt = 0;
    for (int c = 0; c <= lastCyc; c++) begin
      @(posedge clk); #1;
      cpu_en     = 1'b1;
      cpu_wen    = wen;
      cpu_size   = sz;
      cpu_except = exc;
      cpu_addr   = (c == 0) ? a  : ~a;
      cpu_wdata  = (c == 0) ? wd : ~wd;
      addr_ok    = (c == aDel);
      data_ok    = (c == doneCyc) || (spur && c <= aDel);
      rdata      = (c == doneCyc) ? rd : (32'hBAD0_0000 + 32'(c));
      cpu_longest_stall = (holdCyc > 0) && (c >= doneCyc) && (c <= doneCyc + holdCyc);
      rdPhase    = (c == doneCyc) && (wen == 4'h0);
      @(negedge clk);
      if (req) reqCnt++;
      if (cpu_stall) stallCnt++;
      if (c > doneCyc) begin
        check({tag, " hold req"},   32'(req),       32'd0);
        check({tag, " hold stall"}, 32'(cpu_stall), 32'd0);
        check({tag, " hold rdata"}, cpu_rdata,      rd);
      end
    end
    @(posedge clk); #1;
    idleInputs();
    check({tag, " req cycles"},   32'(reqCnt),   32'(aDel + 1));
    check({tag, " stall cycles"}, 32'(stallCnt), 32'(doneCyc));
    @(negedge clk);
    check({tag, " idle req"},   32'(req),       32'd0);
    check({tag, " idle stall"}, 32'(cpu_stall), 32'd0);
  endtask

  initial begin
    idleInputs();
    cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_size = 2'd2;
    rst = 1'b1;
    cpu_en = 1'b1; cpu_wen = 4'hF;
    #12;
    check("reset req",   32'(req),       32'd0);
    check("reset wr",    32'(wr),        32'd0);
    check("reset stall", 32'(cpu_stall), 32'd0);
    check("reset rdata", cpu_rdata,      32'd0);
    @(posedge clk); #1;
    idleInputs();
    rst = 1'b0;

    access("word read", 4'h0, 32'h0000_1000, 32'h0, 2'd2, 0, 0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
    access("byte write", 4'h1, 32'h0000_2003, 32'h0000_00A5, 2'd0, 3, 2, 32'h0, 0, 1'b0, 1'b0);
    access("hold read", 4'h0, 32'h0000_1004, 32'h0, 2'd2, 1, 0, 32'h1234_5678, 3, 1'b0, 1'b0);

    // Spurious data_ok while IDLE must not disturb the held load data.
    @(posedge clk); #1;
    data_ok = 1'b1; rdata = 32'hFFFF_0000;
    @(negedge clk);
    check("spurious idle rdata", cpu_rdata,      32'h1234_5678);
    check("spurious idle stall", 32'(cpu_stall), 32'd0);
    @(posedge clk); #1;
    idleInputs();
    @(negedge clk);
    check("after spurious rdata", cpu_rdata, 32'h1234_5678);

    access("spurious addr read", 4'h0, 32'h0000_1008, 32'h0, 2'd1, 2, 1, 32'hCAFE_F00D, 0, 1'b0, 1'b1);

`ifdef DBRIDGE_EXCEPT_GATE_EN
    @(posedge clk); #1;
    cpu_en = 1'b1; cpu_except = 1'b1; cpu_addr = 32'h0000_4001; cpu_wen = 4'h0;
    @(negedge clk);
    check("except req",   32'(req),       32'd0);
    check("except stall", 32'(cpu_stall), 32'd0);
    @(posedge clk); #1;
    idleInputs();
`else
    access("except ignored", 4'h0, 32'h0000_4000, 32'h0, 2'd2, 0, 1, 32'h5555_AAAA, 0, 1'b1, 1'b0);
`endif

    // Reset while waiting for data_ok: outputs drop without a clock edge.
    @(posedge clk); #1;
    cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h0000_3000; cpu_wdata = 32'h0; cpu_size = 2'd2;
    addr_ok = 1'b1;
    reqQ.push_back('{addr: 32'h0000_3000, wdata: 32'h0, size: 2'd2, wr: 1'b0});
    @(posedge clk); #1;
    addr_ok = 1'b0;
    @(negedge clk);
    check("data wait stall", 32'(cpu_stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async reset req",   32'(req),       32'd0);
    check("async reset stall", 32'(cpu_stall), 32'd0);
    check("async reset rdata", cpu_rdata,      32'd0);
    @(posedge clk); #1;
    idleInputs();
    rst = 1'b0;
    @(negedge clk);
    check("post reset req",   32'(req),       32'd0);
    check("post reset stall", 32'(cpu_stall), 32'd0);

    access("read after reset", 4'h0, 32'h0000_100C, 32'h0, 2'd2, 0, 0, 32'h0F0F_0F0F, 0, 1'b0, 1'b0);

    check("request queue drained", 32'(reqQ.size()), 32'd0);
    check("read queue drained",    32'(rdQ.size()),  32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
